// File: rtl/lc2k_program_loader.sv
// Boot loader: receives an LC2K image over a byte stream, writes it into instruction
// memory word by word, and releases cpu_hold only after the trailing checksum matches.
//
//   state  | meaning
//   IDLE   | waiting for start; stream not accepted
//   HDR_HI | expecting word-count MSB
//   HDR_LO | expecting word-count LSB
//   DATA   | assembling 4-byte words and writing them
//   CHK    | expecting the checksum byte
//   DONE   | one-cycle completion pulse
module lc2k_program_loader #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_CHK,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            nh_q, nh_d;
    logic [15:0]           words_left_q, words_left_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [7:0]            xor_q, xor_d;
    // Only the first three bytes need storing; the fourth goes straight to wdata.
    logic [23:0]           asm_q, asm_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  hold_q, hold_d;
    logic                  err_q, err_d;

    logic ready_w;
    logic fire;

    assign ready_w = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CHK);
    assign fire    = rx_valid && ready_w;

    always_comb begin
        state_d      = state_q;
        nh_d         = nh_q;
        words_left_d = words_left_q;
        byte_cnt_d   = byte_cnt_q;
        word_idx_d   = word_idx_q;
        xor_d        = xor_q;
        asm_d        = asm_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        hold_d       = hold_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HDR_HI;
                    err_d      = 1'b0;
                    xor_d      = 8'h00;
                    byte_cnt_d = 2'd0;
                    word_idx_d = '0;
                    hold_d     = 1'b1;
                end
            end
            S_HDR_HI: begin
                if (fire) begin
                    nh_d    = rx_data;
                    xor_d   = xor_q ^ rx_data;
                    state_d = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (fire) begin
                    words_left_d = {nh_q, rx_data};
                    xor_d        = xor_q ^ rx_data;
                    state_d      = ({nh_q, rx_data} == 16'd0) ? S_CHK : S_DATA;
                end
            end
            S_DATA: begin
                if (fire) begin
                    xor_d      = xor_q ^ rx_data;
                    asm_d      = {asm_q[15:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d         = 1'b1;
                        addr_d       = word_idx_q;
                        wdata_d      = {asm_q, rx_data};
                        word_idx_d   = word_idx_q + ADDR_WIDTH'(1);
                        words_left_d = words_left_q - 16'd1;
                        // Termination uses the 16-bit count, so an oversized image still ends.
                        if (words_left_q == 16'd1) begin
                            state_d = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (fire) begin
                    err_d   = (rx_data != xor_q);
                    hold_d  = (rx_data != xor_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            nh_q         <= 8'h00;
            words_left_q <= 16'd0;
            byte_cnt_q   <= 2'd0;
            word_idx_q   <= '0;
            xor_q        <= 8'h00;
            asm_q        <= 24'h0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            hold_q       <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            nh_q         <= nh_d;
            words_left_q <= words_left_d;
            byte_cnt_q   <= byte_cnt_d;
            word_idx_q   <= word_idx_d;
            xor_q        <= xor_d;
            asm_q        <= asm_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            hold_q       <= hold_d;
            err_q        <= err_d;
        end
    end

    assign rx_ready   = ready_w;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_lc2k_program_loader.sv
// Self-checking bench for lc2k_program_loader: table of whole-image loads plus
// hand-written reset, idle-stream and mid-load-reset sequences.
`timescale 1ns/1ps
module tb_lc2k_program_loader;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;

    lc2k_program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [7:0]  b[16];
        bit          bp;
        bit          xs;
        int          nw;
        logic [31:0] wd[2];
        bit          e_err;
        bit          e_hold;
    } load_vec_t;

    load_vec_t     vecs[5];
    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    int            n_pass = 0;
    int            n_total = 0;

    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    endtask

    function automatic load_vec_t mk(input int n, input logic [127:0] s, input bit bp,
                                     input bit xs, input int nw, input logic [31:0] w0,
                                     input logic [31:0] w1, input bit e_err, input bit e_hold);
        load_vec_t v;
        v.n = n;
        for (int k = 0; k < 16; k++) v.b[k] = s[127-8*k -: 8];
        v.bp     = bp;
        v.xs     = xs;
        v.nw     = nw;
        v.wd[0]  = w0;
        v.wd[1]  = w1;
        v.e_err  = e_err;
        v.e_hold = e_hold;
        return v;
    endfunction

    task automatic run_load(input load_vec_t v);
        int k;
        int cyc;
        bit give;
        bit fire;
        bit wend;
        wa_q.delete();
        wd_q.delete();
        k   = 0;
        cyc = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("ready_after_start", 32'(rx_ready), 32'd1);
        check("err_cleared_by_start", 32'(err), 32'd0);
        check("hold_set_by_start", 32'(cpu_hold), 32'd1);
        while (k < v.n && cyc < 400) begin
            give     = !v.bp || (cyc % 2 == 0);
            rx_valid = give;
            rx_data  = v.b[k];
            start    = v.xs && (cyc == 6 || cyc == 13);
            fire     = give && rx_ready;
            wend     = fire && k >= 2 && k < v.n - 1 && ((k - 2) % 4 == 3);
            @(posedge clk); #1;
            check("we_timing", 32'(imem_we), 32'(wend));
            if (fire) k++;
            cyc++;
        end
        rx_valid = 1'b0;
        start    = 1'b0;
        if (k < v.n) check("load_timeout_bytes", 32'(k), 32'(v.n));
        check("done_pulse", 32'(done), 32'd1);
        check("err_at_done", 32'(err), 32'(v.e_err));
        check("hold_at_done", 32'(cpu_hold), 32'(v.e_hold));
        check("busy_in_done", 32'(busy), 32'd1);
        check("ready_in_done", 32'(rx_ready), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("hold_after_done", 32'(cpu_hold), 32'(v.e_hold));
        check("err_after_done", 32'(err), 32'(v.e_err));
        check("write_count", 32'(wa_q.size()), 32'(v.nw));
        for (int i = 0; i < v.nw && i < wa_q.size(); i++) begin
            check("write_addr", 32'(wa_q[i]), 32'(i));
            check("write_data", wd_q[i], v.wd[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(11, {88'h00_02_01_80_00_00_00_00_00_05_86, 40'h0}, 1'b0, 1'b0, 2,
                     32'h0180_0000, 32'h0000_0005, 1'b0, 1'b0);
        vecs[1] = mk(11, {88'h00_02_01_80_00_00_00_00_00_05_87, 40'h0}, 1'b0, 1'b0, 2,
                     32'h0180_0000, 32'h0000_0005, 1'b1, 1'b1);
        vecs[2] = mk(3, {24'h00_00_00, 104'h0}, 1'b0, 1'b0, 0,
                     32'h0, 32'h0, 1'b0, 1'b0);
        vecs[3] = mk(11, {88'h00_02_01_80_00_00_00_00_00_05_86, 40'h0}, 1'b1, 1'b1, 2,
                     32'h0180_0000, 32'h0000_0005, 1'b0, 1'b0);
        vecs[4] = mk(7, {56'h00_01_DE_AD_BE_EF_23, 72'h0}, 1'b0, 1'b0, 1,
                     32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        rst_n = 1'b1;

        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle_ready", 32'(rx_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        rx_valid = 1'b0;

        run_load(vecs[0]);
        run_load(vecs[1]);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", 32'(err), 32'd1);
        check("hold_sticky", 32'(cpu_hold), 32'd1);
        run_load(vecs[2]);
        run_load(vecs[3]);

        wa_q.delete();
        wd_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1;
            rx_data  = vecs[0].b[i];
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd1);
        check("midrst_ready", 32'(rx_ready), 32'd0);
        check("midrst_we", 32'(imem_we), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_no_writes", 32'(wa_q.size()), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_load(vecs[0]);
        run_load(vecs[4]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
